lfsr_rng_gen: RTL and testbench

//   Parametrised Fibonacci-LFSR random word generator. Successor to the fixed 13-bit generator.

---
 rtl/lfsr_pkg.sv | 15 +
 rtl/lfsr_core.sv | 25 ++
 rtl/lfsr_rng_gen.sv | 109 ++++++++++
 tb/tb_lfsr_rng_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and default tap masks for the LFSR random word generator
package lfsr_pkg;

    typedef enum logic {
        SHIFT = 1'b0,
        HOLD  = 1'b1
    } fsm_t;

    // Maximal-length masks for a left-shifting Fibonacci LFSR, bit i feeds the XOR
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [12:0] TAPS_W13 = 13'h100D;
    localparam logic [15:0] TAPS_W16 = 16'hD008;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - Fibonacci LFSR state register with synchronous load and shift strobe
module lfsr_core #(
    parameter int                 WIDTH = 13,
    parameter logic [WIDTH-1:0]   TAPS  = 13'h100D
) (
    input  logic             clock,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             shift,
    output logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] state_next
);

    assign state_next = {state[WIDTH-2:0], ^(state & TAPS)};

    // Load outranks shift so reset and reseed never advance the register
    always_ff @(posedge clock) begin
        if (load) begin
            state <= load_value;
        end else if (shift) begin
            state <= state_next;
        end
    end

endmodule

// File: rtl/lfsr_rng_gen.sv
// rtl/lfsr_rng_gen.sv - LFSR random word generator with bounded output and ready/valid handshake
module lfsr_rng_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH  = 13,
    parameter logic [WIDTH-1:0] TAPS   = TAPS_W13,
    parameter logic [WIDTH-1:0] SEED   = 13'h000F,
    parameter int               SHIFTS = 13,
    parameter int               RCW    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic [WIDTH-1:0] limit,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] rnd,
    output logic [RCW-1:0]   rejects
);

    localparam int             CW      = $clog2(SHIFTS + 1);
    localparam logic [CW-1:0]  LAST    = CW'(SHIFTS - 1);
    localparam logic [RCW-1:0] REJ_MAX = '1;

    generate
        if (SEED == '0) begin : g_bad_seed
            $error("lfsr_rng_gen: SEED must be non-zero");
        end
        if (WIDTH < 3) begin : g_bad_width
            $error("lfsr_rng_gen: WIDTH must be at least 3");
        end
        if (SHIFTS < 1) begin : g_bad_shifts
            $error("lfsr_rng_gen: SHIFTS must be at least 1");
        end
    endgenerate

    fsm_t             fsm;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] state_next;
    logic [WIDTH-1:0] load_value;
    logic             load;
    logic             shift;
    logic             word_done;
    logic             accept;

    // A zero seed would lock the LFSR, so it is replaced by the build-time seed
    assign load       = reset | seed_load;
    assign load_value = (reset || (seed_in == '0)) ? SEED : seed_in;
    assign shift      = (fsm == SHIFT) && enable;
    assign word_done  = shift && (count == LAST);
    assign accept     = (limit == '0) || (state_next < limit);

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_core (
        .clock      (clock),
        .load       (load),
        .load_value (load_value),
        .shift      (shift),
        .state      (state),
        .state_next (state_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            fsm       <= SHIFT;
            count     <= '0;
            out_valid <= 1'b0;
            rnd       <= '0;
            rejects   <= '0;
        end else if (seed_load) begin
            fsm       <= SHIFT;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                SHIFT: begin
                    if (word_done) begin
                        count <= '0;
                        if (accept) begin
                            rnd       <= state_next;
                            out_valid <= 1'b1;
                            fsm       <= HOLD;
                        end else if (rejects != REJ_MAX) begin
                            rejects <= rejects + 1'b1;
                        end
                    end else if (shift) begin
                        count <= count + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= SHIFT;
                    end
                end
                default: begin
                    fsm       <= SHIFT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_rng_gen.sv
// tb/tb_lfsr_rng_gen.sv - scoreboard bench for lfsr_rng_gen with default parameters
module tb_lfsr_rng_gen;

    localparam logic [12:0] SEED_V = 13'h000F;
    localparam logic [12:0] FIRST  = 13'h1FF4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [12:0] seed_in = '0;
    logic [12:0] limit = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [12:0] rnd;
    logic [7:0]  rejects;

    always #5 clock = ~clock;

    lfsr_rng_gen dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .limit     (limit),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .rnd       (rnd),
        .rejects   (rejects)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [12:0] m_state = SEED_V;
    int          m_count = 0;
    bit          m_hold  = 1'b0;
    logic [12:0] m_rnd   = '0;
    logic [7:0]  m_rej   = '0;
    logic [12:0] exp_q[$];
    logic [12:0] got_q[$];
    logic [12:0] t2_seq[40];

    bit prev_valid = 1'b0;
    bit rose       = 1'b0;
    int cyc        = 0;
    int last_rise  = 0;
    int rise_gap   = 0;
    int took       = 0;
    int t3_words   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [12:0] lfsr_next(input logic [12:0] s);
        return {s[11:0], s[12] ^ s[3] ^ s[2] ^ s[0]};
    endfunction

    // Drive one cycle, advance the reference model, then check the DUT after the edge
    task automatic tick(input bit rst, input bit sl, input bit en, input bit rdy,
                        input logic [12:0] sin, input logic [12:0] lim);
        reset = rst; seed_load = sl; enable = en; out_ready = rdy;
        seed_in = sin; limit = lim;
        if (rst) begin
            m_state = SEED_V; m_count = 0; m_hold = 1'b0; m_rnd = '0; m_rej = '0;
            exp_q.delete();
        end else if (sl) begin
            m_state = (sin == '0) ? SEED_V : sin; m_count = 0; m_hold = 1'b0;
            exp_q.delete();
        end else if (m_hold) begin
            if (rdy) m_hold = 1'b0;
        end else if (en) begin
            m_state = lfsr_next(m_state);
            m_count++;
            if (m_count == 13) begin
                m_count = 0;
                if (lim == '0 || m_state < lim) begin
                    exp_q.push_back(m_state);
                    m_rnd  = m_state;
                    m_hold = 1'b1;
                end else if (m_rej != 8'hFF) begin
                    m_rej++;
                end
            end
        end
        @(posedge clock);
        #1;
        cyc++;
        check_eq("out_valid", out_valid, m_hold);
        check_eq("rejects", rejects, m_rej);
        rose = out_valid && !prev_valid;
        if (rose) begin
            rise_gap  = cyc - last_rise;
            last_rise = cyc;
            got_q.push_back(rnd);
            check_eq("queue_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) check_eq("word", rnd, exp_q.pop_front());
        end
        if (out_valid) check_eq("rnd_stable", rnd, m_rnd);
        prev_valid = out_valid;
    endtask

    task automatic run_until_word(input int budget, input bit rand_io, input bit rdy,
                                  input logic [12:0] lim, output int n);
        n = 0;
        do begin
            tick(1'b0, 1'b0,
                 rand_io ? 1'($urandom_range(0, 1)) : 1'b1,
                 rand_io ? 1'($urandom_range(0, 1)) : rdy,
                 '0, lim);
            n++;
        end while (!rose && n < budget);
        check_eq("word_seen", rose, 1);
    endtask

    initial begin
        // T1: reset state, first word latency and value, hold stability
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        check_eq("reset_rnd", rnd, 0);
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_rejects", rejects, 0);
        run_until_word(40, 1'b0, 1'b0, '0, took);
        check_eq("t1_latency", took, 13);
        check_eq("t1_first_rnd", rnd, FIRST);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        check_eq("t1_hold_valid", out_valid, 1);
        check_eq("t1_hold_rnd", rnd, FIRST);

        // T2: handshake timing and 1000-word sequence
        tick(1'b0, 1'b0, 1'b1, 1'b1, '0, '0);
        check_eq("t2_drop", out_valid, 0);
        run_until_word(40, 1'b0, 1'b0, '0, took);
        check_eq("t2_gap_after_ready", took + 1, 14);
        for (int i = 0; i < 1000; i++) begin
            run_until_word(40, 1'b0, 1'b1, '0, took);
            check_eq("t2_period", rise_gap, 14);
        end
        for (int i = 0; i < 40; i++) t2_seq[i] = got_q[i];

        // T3: rejection-bounded output and saturating reject counter
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, 13'h1000);
        for (int i = 0; i < 13; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, '0, 13'h1000);
        check_eq("t3_no_valid_13", out_valid, 0);
        check_eq("t3_first_reject", rejects, 1);
        for (int i = 0; i < 12000; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1, '0, 13'h1000);
            if (rose) begin
                t3_words++;
                check_eq("t3_bound", rnd < 13'h1000, 1);
            end
        end
        check_eq("t3_saturated", rejects, 8'hFF);
        check_eq("t3_some_words", t3_words > 0, 1);

        // T4: reseed mid-word and in HOLD
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, '0, '0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, '0, '0);
        check_eq("t4_load_no_valid", out_valid, 0);
        run_until_word(40, 1'b0, 1'b0, '0, took);
        check_eq("t4_latency", took, 13);
        check_eq("t4_rnd", rnd, FIRST);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 13'h0ABC, '0);
        check_eq("t4_hold_load_drop", out_valid, 0);
        run_until_word(40, 1'b0, 1'b0, '0, took);
        check_eq("t4_reseed_latency", took, 13);

        // T5: random enable and ready only stretch timing
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        got_q.delete();
        for (int i = 0; i < 40; i++) run_until_word(400, 1'b1, 1'b0, '0, took);
        check_eq("t5_count", got_q.size(), 40);
        for (int i = 0; i < 40 && i < got_q.size(); i++) check_eq("t5_seq", got_q[i], t2_seq[i]);

        // T6: reset beats seed_load while holding a word with rejects pending
        tick(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        run_until_word(400, 1'b0, 1'b0, 13'h1000, took);
        check_eq("t6_has_rejects", rejects != 0, 1);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 13'h0123, '0);
        check_eq("t6_valid", out_valid, 0);
        check_eq("t6_rnd", rnd, 0);
        check_eq("t6_rejects", rejects, 0);
        run_until_word(40, 1'b0, 1'b0, '0, took);
        check_eq("t6_latency", took, 13);
        check_eq("t6_rnd_first", rnd, FIRST);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
